// File: rtl/share_pkg.sv
// Shared constants, types and the LFSR advance function for the two-share encoder.
package share_pkg;

   localparam int unsigned SHARE_W      = 8;
   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] SEED_DEFAULT = 32'hACE1_1CEA;

   typedef enum logic {WARM, RUN} enc_state_t;

   // Sixteen right-shift Galois steps; one call yields a fresh 16-bit mask window.
   function automatic logic [31:0] lfsr_step16(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      for (int i = 0; i < 16; i++) begin
         if (r[0]) begin
            r = (r >> 1) ^ LFSR_POLY;
         end else begin
            r = r >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/share_lfsr16.sv
// 32-bit mask LFSR register with load, 16-step advance and hold.
module share_lfsr16
   import share_pkg::*;
#(
   parameter logic [31:0] RESET_SEED = 32'hACE1_1CEA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        advance,
   output logic [31:0] state
);

   // Load beats advance; otherwise the state holds so no mask window is skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_SEED;
      end else if (load) begin
         state <= load_val;
      end else if (advance) begin
         state <= lfsr_step16(state);
      end
   end

endmodule

// File: rtl/share_split_encoder.sv
// Splits plain operand pairs into two Boolean shares using fresh LFSR masks.
module share_split_encoder #(
   parameter int unsigned W            = 8,
   parameter logic [31:0] SEED_DEFAULT = 32'hACE1_1CEA,
   parameter int unsigned WARMUP_CYC   = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         seed_load,
   input  logic [31:0]  seed,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] a0,
   output logic [W-1:0] a1,
   output logic [W-1:0] b0,
   output logic [W-1:0] b1,
   output logic         busy
);

   import share_pkg::*;

   localparam logic [3:0] WARM_LAST = 4'(WARMUP_CYC - 1);

   enc_state_t  state_q;
   logic [3:0]  warm_cnt_q;
   logic [31:0] lfsr_s;
   logic [31:0] lfsr_load_val;
   logic        lfsr_adv;
   logic        accept;
   logic [W-1:0] ma;
   logic [W-1:0] mb;

   assign ma = lfsr_s[W-1:0];
   assign mb = lfsr_s[2*W-1:W];

   // Handshake and LFSR control; a reseed pulse blocks acceptance in the same cycle.
   always_comb begin
      in_ready      = (state_q == RUN) && !seed_load && (!out_valid || out_ready);
      accept        = in_valid && in_ready;
      lfsr_load_val = (seed == 32'h0) ? SEED_DEFAULT : seed;
      lfsr_adv      = (state_q == WARM) || accept;
      busy          = (state_q == WARM);
   end

   share_lfsr16 #(
      .RESET_SEED (SEED_DEFAULT)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_load),
      .load_val (lfsr_load_val),
      .advance  (lfsr_adv),
      .state    (lfsr_s)
   );

   // Warm-up sequencing: stay in WARM for WARMUP_CYC cycles after reset or any reseed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WARM;
         warm_cnt_q <= 4'd0;
      end else if (seed_load) begin
         state_q    <= WARM;
         warm_cnt_q <= 4'd0;
      end else begin
         unique case (state_q)
            WARM: begin
               if (warm_cnt_q == WARM_LAST) begin
                  state_q    <= RUN;
                  warm_cnt_q <= 4'd0;
               end else begin
                  warm_cnt_q <= warm_cnt_q + 4'd1;
               end
            end
            RUN: begin
               state_q <= RUN;
            end
            default: begin
               state_q    <= WARM;
               warm_cnt_q <= 4'd0;
            end
         endcase
      end
   end

   // Output share register; a pending set survives reseed and is only replaced on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         a0        <= '0;
         a1        <= '0;
         b0        <= '0;
         b1        <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         a0        <= a ^ ma;
         a1        <= ma;
         b0        <= b ^ mb;
         b1        <= mb;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_share_split_encoder.sv
// Directed self-checking bench for share_split_encoder.
module tb_share_split_encoder;

   localparam logic [31:0] SEED = 32'hACE1_1CEA;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seed_load = 1'b0;
   logic [31:0] seed = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = 8'h0;
   logic [7:0]  b = 8'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  a0, a1, b0, b1;
   logic        busy;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_s;
   logic [15:0] first_mask;

   share_split_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a0        (a0),
      .a1        (a1),
      .b0        (b0),
      .b1        (b1),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference LFSR: sixteen single Galois steps.
   function automatic logic [31:0] m_step16(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      for (int i = 0; i < 16; i++) begin
         r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
      end
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy} !== 3'b001) begin
         errors++; $display("FAIL reset_ctrl: got %b want 001", {out_valid, in_ready, busy});
      end
      checks++;
      if ({a0, a1, b0, b1} !== 32'h0) begin
         errors++; $display("FAIL reset_shares: got %h want 0", {a0, a1, b0, b1});
      end
      rst = 1'b0;
      m_s = SEED;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({busy, in_ready} !== 2'b10) begin
            errors++; $display("FAIL warm_%0d: busy/in_ready got %b want 10", i, {busy, in_ready});
         end
         @(posedge clk); #1;
         m_s = m_step16(m_s);
      end
      first_mask = m_s[15:0];
      checks++;
      if ({busy, in_ready} !== 2'b01) begin
         errors++; $display("FAIL warm_done: busy/in_ready got %b want 01", {busy, in_ready});
      end
      checks++;
      if ({a0, a1, b0, b1, out_valid} !== 33'h0) begin
         errors++; $display("FAIL idle_shares: got %h want 0", {a0, a1, b0, b1, out_valid});
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      logic [15:0] prev;
      a = 8'h5A; b = 8'hC3; in_valid = 1'b1; out_ready = 1'b1;
      prev = 16'h0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         exp = m_s;
         m_s = m_step16(m_s);
         checks++;
         if ({out_valid, in_ready} !== 2'b11) begin
            errors++; $display("FAIL stream_hs_%0d: got %b want 11", k, {out_valid, in_ready});
         end
         checks++;
         if ({a0 ^ a1, b0 ^ b1} !== 16'h5AC3) begin
            errors++; $display("FAIL stream_xor_%0d: got %h want 5ac3", k, {a0 ^ a1, b0 ^ b1});
         end
         checks++;
         if ({b1, a1} !== exp[15:0]) begin
            errors++; $display("FAIL stream_mask_%0d: got %h want %h", k, {b1, a1}, exp[15:0]);
         end
         if (k > 0) begin
            checks++;
            if ({b1, a1} === prev) begin
               errors++; $display("FAIL stream_reuse_%0d: got %h want not %h", k, {b1, a1}, prev);
            end
         end
         prev = {b1, a1};
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL stream_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp;
      logic [31:0] held;
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      exp = m_s;
      m_s = m_step16(m_s);
      held = {8'h11 ^ exp[7:0], exp[7:0], 8'h22 ^ exp[15:8], exp[15:8]};
      checks++;
      if ({a0, a1, b0, b1} !== held || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_accept: got %h/%b want %h/1", {a0, a1, b0, b1}, out_valid, held);
      end
      a = 8'hFF; b = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_%0d: got %b want 0", i, in_ready);
         end
         @(posedge clk); #1;
         checks++;
         if ({a0, a1, b0, b1} !== held || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold_%0d: got %h/%b want %h/1", i, {a0, a1, b0, b1}, out_valid, held);
         end
      end
      // Release with a new pair pending: drain and accept in the same cycle.
      out_ready = 1'b1; a = 8'h33; b = 8'h44;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      exp = m_s;
      m_s = m_step16(m_s);
      held = {8'h33 ^ exp[7:0], exp[7:0], 8'h44 ^ exp[15:8], exp[15:8]};
      checks++;
      if ({a0, a1, b0, b1} !== held || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_next: got %h/%b want %h/1", {a0, a1, b0, b1}, out_valid, held);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_reseed_zero();
      logic [31:0] exp;
      logic [31:0] held;
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h77; b = 8'h88;
      @(posedge clk); #1;
      exp = m_s;
      held = {8'h77 ^ exp[7:0], exp[7:0], 8'h88 ^ exp[15:8], exp[15:8]};
      in_valid = 1'b0; seed = 32'h0; seed_load = 1'b1;
      @(posedge clk); #1;
      seed_load = 1'b0;
      m_s = SEED;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({busy, out_valid} !== 2'b11) begin
            errors++; $display("FAIL rs_busy_%0d: busy/out_valid got %b want 11", i, {busy, out_valid});
         end
         checks++;
         if ({a0, a1, b0, b1} !== held) begin
            errors++; $display("FAIL rs_hold_%0d: got %h want %h", i, {a0, a1, b0, b1}, held);
         end
         @(posedge clk); #1;
         m_s = m_step16(m_s);
      end
      checks++;
      if ({busy, in_ready, out_valid} !== 3'b001) begin
         errors++; $display("FAIL rs_done: busy/in_ready/out_valid got %b want 001", {busy, in_ready, out_valid});
      end
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h5A; b = 8'hC3;
      @(posedge clk); #1;
      m_s = m_step16(m_s);
      checks++;
      if ({b1, a1} !== first_mask) begin
         errors++; $display("FAIL rs_first_mask: got %h want %h", {b1, a1}, first_mask);
      end
      checks++;
      if ({a0 ^ a1, b0 ^ b1} !== 16'h5AC3) begin
         errors++; $display("FAIL rs_xor: got %h want 5ac3", {a0 ^ a1, b0 ^ b1});
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_seed_load_accept();
      logic [31:0] exp;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      seed = 32'h1234_5678; seed_load = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL sl_ready: got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      seed_load = 1'b0; in_valid = 1'b0;
      checks++;
      if ({out_valid, busy} !== 2'b01) begin
         errors++; $display("FAIL sl_no_accept: out_valid/busy got %b want 01", {out_valid, busy});
      end
      m_s = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         m_s = m_step16(m_s);
      end
      checks++;
      if ({busy, in_ready} !== 2'b01) begin
         errors++; $display("FAIL sl_warm: busy/in_ready got %b want 01", {busy, in_ready});
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      exp = m_s;
      m_s = m_step16(m_s);
      in_valid = 1'b0;
      checks++;
      if ({a0, a1, b0, b1} !== {8'hAA ^ exp[7:0], exp[7:0], 8'h55 ^ exp[15:8], exp[15:8]}) begin
         errors++; $display("FAIL sl_masks: got %h want %h", {a0, a1, b0, b1},
                            {8'hAA ^ exp[7:0], exp[7:0], 8'h55 ^ exp[15:8], exp[15:8]});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'hC3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_pending: out_valid got %b want 1", out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, in_ready, busy, a0, a1, b0, b1} !== {3'b001, 32'h0}) begin
         errors++; $display("FAIL mid_async: got %h want %h",
                            {out_valid, in_ready, busy, a0, a1, b0, b1}, {3'b001, 32'h0});
      end
      test_reset();
      test_stream();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_reseed_zero();
      test_seed_load_accept();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
